bsg_packet_rx_checker: RTL
==========================

Name: bsg_packet_rx_checker

Overview:
- Ingress stage directly upstream of the store-and-forward buffer.
- Receives a raw packet stream where the final beat of every packet is an XOR checksum word.
- Strips the checksum beat, moves last onto the final payload word, and flags error on that word for checksum mismatch or oversize.
- The downstream buffer sees complete packets with correct last/error and commits or drops them.

Parameters:
- width_p, none (must be set), data word width; the checksum word is also width_p bits.
- max_els_p, none (must be set), max payload words per packet (checksum excluded); larger packets are flagged error.
- len_width_lp, `BSG_SAFE_CLOG2(max_els_p+2), localparam, length counter width.

Ports:
- clk_i  in  1  clock
- reset_i  in  1  synchronous active-high reset
- data_i  in  width_p  input beat
- v_i  in  1  input valid
- last_i  in  1  beat is the checksum (final) beat
- ready_o  out  1  input ready; beat accepted when v_i & ready_o
- data_o  out  width_p  payload word
- v_o  out  1  output valid
- last_o  out  1  final payload word of the packet
- error_o  out  1  packet bad; meaningful only when v_o & last_o
- ready_i  in  1  downstream ready; beat leaves when v_o & ready_i
- runt_drop_o  out  1  one-cycle pulse: single-beat packet dropped

Behaviour:
- Registers:
  - hold: hold_v_r, hold_data_r. Holds a payload word whose last status is not yet known.
  - out: out_v_r, out_data_r, out_last_r, out_err_r.
  - csum_r (width_p): running XOR of accepted payload words.
  - len_r: payload count, saturating at max_els_p+1.
- Reset:
  - hold_v_r, out_v_r, csum_r, len_r and runt_drop_o are all 0.
  - v_o=0, last_o=0, error_o=0.
  - ready_o=1 in the first cycle after reset.
  - Reset mid-packet discards the partial packet; the next beat starts a new packet.
- Output mapping: v_o=out_v_r, data_o=out_data_r, last_o=out_last_r, error_o=out_err_r&out_last_r.
- out_free = ~out_v_r | ready_i.
- ready_o = ~hold_v_r | out_free. There is no combinational path from v_i to v_o.
- Accepted non-last beat:
  - If hold_v_r: out <= {hold_data_r, last=0, err=0}.
  - hold <= data_i.
  - csum_r ^= data_i; len_r++ (saturating).
- Accepted last beat with hold_v_r:
  - out <= {hold_data_r, last=1, err=(csum_r!=data_i) | (len_r>max_els_p)}.
  - hold_v_r <= 0; csum_r <= 0; len_r <= 0.
  - The checksum beat is never forwarded.
- Accepted last beat with ~hold_v_r (runt):
  - Nothing is emitted; runt_drop_o=1 next cycle.
  - csum_r and len_r are cleared.
- If out drains and no move into out occurs in the same cycle: out_v_r <= 0.
- Simultaneous drain and refill of out in one cycle is legal. Full throughput is 1 beat/cycle.
- Latency: payload word k appears on v_o 1 cycle after beat k+1 (payload or checksum) is accepted. Empty pipe: 2 cycles from the first accepted word to v_o.
- Backpressure: ready_o drops only when hold and out are both occupied and ~ready_i. Beats are never lost.
- Oversize: len saturates, so an arbitrarily long packet still yields exactly one error on its last word. Payloads exactly max_els_p long are good.
- Back-to-back packets: the first beat of packet N+1 may be accepted the cycle after packet N's checksum beat.

Decomposition:
- Package bsg_packet_rx_pkg holds:
  - an error-cause enum {e_ok, e_csum, e_oversize}, used internally and by the bench;
  - the checksum seed constant (0).
- Optional sub-module bsg_packet_rx_csum_len holds csum_r and len_r (clear/accumulate/saturate), reused by the matching tx checksum inserter.

Test Plan:
- width_p=8, max_els_p=4.
  - Stimulus: send 11,22,33,last=00 (csum 11^22^33=00).
  - Response: out 11,22,33 with last on 33 and error_o=0.
- Same payload with checksum FF -> identical data, error_o=1 on 33.
- Five payload words 01,02,04,08,10 with checksum 1F -> all five emitted; error_o=1 on 10 (oversize). Four words 01,02,04,08 with csum 0F -> error_o=0.
- Single beat last=1 data=AA -> no v_o; runt_drop_o pulses once. The following packet 05,last=05 -> 05 with last=1 and error_o=0.
- Stream 3 back-to-back good packets with ready_i held 0 for 5 cycles mid-stream:
  - ready_o falls only when both registers are full;
  - no beat is lost or duplicated;
  - order is preserved;
  - once drained, throughput returns to 1/cycle.
- Assert reset_i after 2 payload words of a packet, then send 07,last=07 -> single word 07 with last=1 and error_o=0; no stale output.

Source files
------------

// File: rtl/bsg_packet_rx_pkg.sv
// Shared types and constants for the packet rx checker and its tx counterpart.
package bsg_packet_rx_pkg;

    typedef enum logic [1:0] {
        e_ok,
        e_csum,
        e_oversize
    } err_cause_e;

    localparam int unsigned CsumSeed = 0;

    // Oversize wins over a bad checksum when both apply; either one marks the packet bad.
    function automatic err_cause_e classify_err(input logic csum_bad, input logic oversize);
        if (oversize) begin
            return e_oversize;
        end
        if (csum_bad) begin
            return e_csum;
        end
        return e_ok;
    endfunction

endpackage

// File: rtl/bsg_packet_rx_csum_len.sv
// Running XOR checksum and saturating payload-length counter for one packet.
module bsg_packet_rx_csum_len
    import bsg_packet_rx_pkg::*;
#(
    parameter int unsigned width_p      = 8,
    parameter int unsigned max_els_p    = 4,
    parameter int unsigned len_width_lp = $clog2(max_els_p + 2)
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    clear_i,
    input  logic                    accum_i,
    input  logic [width_p-1:0]      data_i,
    output logic [width_p-1:0]      csum_o,
    output logic [len_width_lp-1:0] len_o
);

    localparam logic [width_p-1:0]      Seed   = width_p'(CsumSeed);
    localparam logic [len_width_lp-1:0] LenSat = len_width_lp'(max_els_p + 1);
    localparam logic [len_width_lp-1:0] LenOne = len_width_lp'(1);

    logic [width_p-1:0]      csum_d, csum_q;
    logic [len_width_lp-1:0] len_d, len_q;

    // Saturating one past the limit keeps any oversize packet flagged exactly once.
    always_comb begin
        csum_d = csum_q;
        len_d  = len_q;
        if (clear_i) begin
            csum_d = Seed;
            len_d  = '0;
        end else if (accum_i) begin
            csum_d = csum_q ^ data_i;
            if (len_q != LenSat) begin
                len_d = len_q + LenOne;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            csum_q <= Seed;
            len_q  <= '0;
        end else begin
            csum_q <= csum_d;
            len_q  <= len_d;
        end
    end

    assign csum_o = csum_q;
    assign len_o  = len_q;

endmodule

// File: rtl/bsg_packet_rx_checker.sv
// Strips the trailing XOR checksum beat, moves last onto the final payload word
// and flags checksum mismatch or oversize on it.
module bsg_packet_rx_checker
    import bsg_packet_rx_pkg::*;
#(
    parameter int unsigned width_p   = 8,
    parameter int unsigned max_els_p = 4
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic [width_p-1:0] data_i,
    input  logic               v_i,
    input  logic               last_i,
    output logic               ready_o,
    output logic [width_p-1:0] data_o,
    output logic               v_o,
    output logic               last_o,
    output logic               error_o,
    input  logic               ready_i,
    output logic               runt_drop_o
);

    localparam int unsigned len_width_lp = $clog2(max_els_p + 2);
    localparam logic [len_width_lp-1:0] LenMax = len_width_lp'(max_els_p);

    logic               hold_v_d, hold_v_q;
    logic [width_p-1:0] hold_data_d, hold_data_q;
    logic               out_v_d, out_v_q;
    logic [width_p-1:0] out_data_d, out_data_q;
    logic               out_last_d, out_last_q;
    logic               out_err_d, out_err_q;
    logic               runt_d, runt_q;

    logic                    out_free;
    logic                    accept;
    logic                    acc_payload;
    logic                    acc_last;
    logic                    move_out;
    logic [width_p-1:0]      csum;
    logic [len_width_lp-1:0] len;
    err_cause_e              cause;

    assign out_free    = ~out_v_q | ready_i;
    assign ready_o     = ~hold_v_q | out_free;
    assign accept      = v_i & ready_o;
    assign acc_payload = accept & ~last_i;
    assign acc_last    = accept & last_i;
    // Any accepted beat resolves the held word's last status, so it can advance.
    assign move_out    = accept & hold_v_q;
    assign cause       = classify_err(csum != data_i, len > LenMax);

    bsg_packet_rx_csum_len #(
        .width_p      (width_p),
        .max_els_p    (max_els_p),
        .len_width_lp (len_width_lp)
    ) u_csum_len (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .clear_i (acc_last),
        .accum_i (acc_payload),
        .data_i  (data_i),
        .csum_o  (csum),
        .len_o   (len)
    );

    always_comb begin
        hold_v_d    = hold_v_q;
        hold_data_d = hold_data_q;
        out_v_d     = out_v_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        out_err_d   = out_err_q;
        runt_d      = acc_last & ~hold_v_q;

        if (acc_payload) begin
            hold_v_d    = 1'b1;
            hold_data_d = data_i;
        end else if (acc_last) begin
            hold_v_d = 1'b0;
        end

        if (move_out) begin
            out_v_d    = 1'b1;
            out_data_d = hold_data_q;
            out_last_d = last_i;
            out_err_d  = last_i & (cause != e_ok);
        end else if (ready_i) begin
            out_v_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            hold_v_q    <= 1'b0;
            hold_data_q <= '0;
            out_v_q     <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            out_err_q   <= 1'b0;
            runt_q      <= 1'b0;
        end else begin
            hold_v_q    <= hold_v_d;
            hold_data_q <= hold_data_d;
            out_v_q     <= out_v_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            out_err_q   <= out_err_d;
            runt_q      <= runt_d;
        end
    end

    assign v_o         = out_v_q;
    assign data_o      = out_data_q;
    assign last_o      = out_last_q;
    assign error_o     = out_err_q & out_last_q;
    assign runt_drop_o = runt_q;

endmodule
